// File: rtl/banked_array_regfile.sv
// Banked register file: one dynamically indexed read port per bank, a handshaked
// masked write port and a bulk-clear sweep that zeroes one entry per cycle.
module banked_array_regfile #(
    parameter int unsigned NBANKS       = 2,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned ELEMS        = 3,
    parameter int unsigned EWIDTH       = 2,
    parameter int unsigned READ_LATENCY = 0,
    localparam int unsigned AW = (DEPTH > 2) ? $clog2(DEPTH) : 1,
    localparam int unsigned BW = (NBANKS > 2) ? $clog2(NBANKS) : 1,
    localparam int unsigned EW = ELEMS * EWIDTH
) (
    input  logic                 CLK,
    input  logic                 ASYNCRESET,
    input  logic                 wvalid,
    output logic                 wready,
    input  logic [BW-1:0]        wbank,
    input  logic [AW-1:0]        waddr,
    input  logic [EW-1:0]        wdata,
    input  logic [ELEMS-1:0]     wmask,
    input  logic [NBANKS*AW-1:0] raddr,
    output logic [NBANKS*EW-1:0] rdata,
    input  logic                 clear_req,
    output logic                 busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [0:0]           state;
    logic [0:0]           state_nxt;
    logic [AW-1:0]        cnt;
    logic [AW-1:0]        cnt_nxt;
    logic                 wr_fire;
    logic                 sweep_last;
    logic [EW-1:0]        mem [NBANKS][DEPTH];
    logic [NBANKS*EW-1:0] rd_c;

    assign wr_fire    = wvalid && wready;
    assign sweep_last = (32'(cnt) == DEPTH - 1);

    // Next-state and sweep counter
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                if (sweep_last) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + AW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State register; handshake outputs follow the next state so they are flops
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state  <= IDLE;
            cnt    <= '0;
            wready <= 1'b1;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            wready <= (state_nxt == IDLE);
            busy   <= (state_nxt == CLEAR);
        end
    end

    // Storage: full-width index matches make out-of-range writes fall through untouched
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            for (int unsigned b = 0; b < NBANKS; b++) begin
                for (int unsigned a = 0; a < DEPTH; a++) begin
                    mem[b][a] <= '0;
                end
            end
        end else begin
            for (int unsigned b = 0; b < NBANKS; b++) begin
                for (int unsigned a = 0; a < DEPTH; a++) begin
                    if (state == CLEAR && 32'(cnt) == a) begin
                        mem[b][a] <= '0;
                    end else if (wr_fire && 32'(wbank) == b && 32'(waddr) == a) begin
                        for (int unsigned e = 0; e < ELEMS; e++) begin
                            if (wmask[e]) begin
                                mem[b][a][e*EWIDTH +: EWIDTH] <= wdata[e*EWIDTH +: EWIDTH];
                            end
                        end
                    end
                end
            end
        end
    end

    // Per-bank read mux; an address beyond DEPTH matches nothing and reads 0
    always_comb begin
        rd_c = '0;
        for (int unsigned b = 0; b < NBANKS; b++) begin
            for (int unsigned a = 0; a < DEPTH; a++) begin
                if (32'(raddr[b*AW +: AW]) == a) begin
                    rd_c[b*EW +: EW] = mem[b][a];
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 0) begin : g_comb_read
            assign rdata = rd_c;
        end else begin : g_reg_read
            // Samples pre-write storage, so a same-edge write is not bypassed
            always_ff @(posedge CLK or posedge ASYNCRESET) begin
                if (ASYNCRESET) begin
                    rdata <= '0;
                end else begin
                    rdata <= rd_c;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_banked_array_regfile.sv
// Bench for banked_array_regfile: two 2x4 instances (comb and registered read) share
// stimulus, a 3x3 instance covers out-of-range handling; all checked against a model.
module tb_banked_array_regfile;

    logic CLK = 1'b0;
    logic ASYNCRESET;
    always #5 CLK = ~CLK;

    logic        wvalid, clear_req;
    logic [0:0]  wbank;
    logic [1:0]  waddr;
    logic [5:0]  wdata;
    logic [2:0]  wmask;
    logic [3:0]  raddr;
    logic        a_wready, a_busy, b_wready, b_busy;
    logic [11:0] a_rdata, b_rdata;

    logic        c_wvalid, c_clear;
    logic [1:0]  c_wbank, c_waddr;
    logic [5:0]  c_wdata;
    logic [2:0]  c_wmask;
    logic [5:0]  c_raddr;
    logic        c_wready, c_busy;
    logic [17:0] c_rdata;

    banked_array_regfile #(.NBANKS(2), .DEPTH(4), .ELEMS(3), .EWIDTH(2), .READ_LATENCY(0)) u_dut_a (
        .CLK(CLK), .ASYNCRESET(ASYNCRESET), .wvalid(wvalid), .wready(a_wready),
        .wbank(wbank), .waddr(waddr), .wdata(wdata), .wmask(wmask), .raddr(raddr),
        .rdata(a_rdata), .clear_req(clear_req), .busy(a_busy));

    banked_array_regfile #(.NBANKS(2), .DEPTH(4), .ELEMS(3), .EWIDTH(2), .READ_LATENCY(1)) u_dut_b (
        .CLK(CLK), .ASYNCRESET(ASYNCRESET), .wvalid(wvalid), .wready(b_wready),
        .wbank(wbank), .waddr(waddr), .wdata(wdata), .wmask(wmask), .raddr(raddr),
        .rdata(b_rdata), .clear_req(clear_req), .busy(b_busy));

    banked_array_regfile #(.NBANKS(3), .DEPTH(3), .ELEMS(3), .EWIDTH(2), .READ_LATENCY(0)) u_dut_c (
        .CLK(CLK), .ASYNCRESET(ASYNCRESET), .wvalid(c_wvalid), .wready(c_wready),
        .wbank(c_wbank), .waddr(c_waddr), .wdata(c_wdata), .wmask(c_wmask), .raddr(c_raddr),
        .rdata(c_rdata), .clear_req(c_clear), .busy(c_busy));

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: group 0 = the 2x4 pair, group 1 = the 3x3 instance
    logic [5:0] mm [2][3][4];
    bit         mbusy [2];
    int         mpos [2];
    logic [5:0] exp_rl1 [2];

    function automatic int nbk(input int g);
        return (g == 0) ? 2 : 3;
    endfunction

    function automatic int dpt(input int g);
        return (g == 0) ? 4 : 3;
    endfunction

    function automatic logic [5:0] mread(input int g, input int b, input int a);
        if (b >= nbk(g) || a >= dpt(g)) return 6'd0;
        return mm[g][b][a];
    endfunction

    task automatic mstep(input int g, input bit wv, input int wb, input int wa,
                         input logic [5:0] wd, input logic [2:0] wm, input bit clr);
        if (mbusy[g]) begin
            for (int b = 0; b < nbk(g); b++) mm[g][b][mpos[g]] = 6'd0;
            mpos[g]++;
            if (mpos[g] == dpt(g)) mbusy[g] = 1'b0;
        end else begin
            if (wv && wb < nbk(g) && wa < dpt(g)) begin
                for (int e = 0; e < 3; e++) begin
                    if (wm[e]) mm[g][wb][wa][e*2 +: 2] = wd[e*2 +: 2];
                end
            end
            if (clr) begin
                mbusy[g] = 1'b1;
                mpos[g]  = 0;
            end
        end
    endtask

    always @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            for (int g = 0; g < 2; g++) begin
                for (int b = 0; b < 3; b++) begin
                    for (int a = 0; a < 4; a++) mm[g][b][a] = 6'd0;
                end
                mbusy[g]   = 1'b0;
                mpos[g]    = 0;
                exp_rl1[g] = 6'd0;
            end
        end else begin
            exp_rl1[0] = mread(0, 0, int'(raddr[1:0]));
            exp_rl1[1] = mread(0, 1, int'(raddr[3:2]));
            mstep(0, wvalid, int'(wbank), int'(waddr), wdata, wmask, clear_req);
            mstep(1, c_wvalid, int'(c_wbank), int'(c_waddr), c_wdata, c_wmask, c_clear);
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge CLK) begin
        if (chk_en && !ASYNCRESET) begin
            chk("a_rdata", 64'(a_rdata),
                64'({mread(0, 1, int'(raddr[3:2])), mread(0, 0, int'(raddr[1:0]))}));
            chk("b_rdata", 64'(b_rdata), 64'({exp_rl1[1], exp_rl1[0]}));
            chk("c_rdata", 64'(c_rdata),
                64'({mread(1, 2, int'(c_raddr[5:4])), mread(1, 1, int'(c_raddr[3:2])),
                     mread(1, 0, int'(c_raddr[1:0]))}));
            chk("a_busy",   64'(a_busy),   64'(mbusy[0]));
            chk("a_wready", 64'(a_wready), 64'(!mbusy[0]));
            chk("b_busy",   64'(b_busy),   64'(mbusy[0]));
            chk("b_wready", 64'(b_wready), 64'(!mbusy[0]));
            chk("c_busy",   64'(c_busy),   64'(mbusy[1]));
            chk("c_wready", 64'(c_wready), 64'(!mbusy[1]));
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        ASYNCRESET = 1'b1;
        wvalid = 1'b0; clear_req = 1'b0; wbank = '0; waddr = '0; wdata = '0; wmask = '0; raddr = '0;
        c_wvalid = 1'b0; c_clear = 1'b0; c_wbank = '0; c_waddr = '0; c_wdata = '0; c_wmask = '0;
        c_raddr = '0;
        repeat (2) step();
        ASYNCRESET = 1'b0;
        chk_en = 1'b1;

        // Mid-cycle reset wipes a written entry immediately
        wvalid = 1'b1; wbank = 1'b0; waddr = 2'd1; wdata = 6'h3F; wmask = 3'b111; raddr = 4'b0001;
        step();
        wvalid = 1'b0;
        #1 chk("pre_reset_read", 64'(a_rdata), 64'h03F);
        #1 ASYNCRESET = 1'b1;
        #1;
        chk("reset_a_rdata", 64'(a_rdata), 64'h0);
        chk("reset_b_rdata", 64'(b_rdata), 64'h0);
        chk("reset_c_rdata", 64'(c_rdata), 64'h0);
        chk("reset_busy", 64'(a_busy), 64'h0);
        step();
        ASYNCRESET = 1'b0;
        #1 chk("release_wready", 64'(a_wready), 64'h1);

        // Masked write: e1 untouched
        wvalid = 1'b1; wbank = 1'b1; waddr = 2'd2; wdata = 6'h36; wmask = 3'b101; raddr = 4'b1000;
        step();
        wvalid = 1'b0;
        chk("mask_write", 64'(a_rdata), 64'hC80);
        chk("model_pin_mask", 64'(mread(0, 1, 2)), 64'h32);

        // Fill: bank0[k] = {k,k,k}, bank1[k] = {3-k,...}
        for (int k = 0; k < 4; k++) begin
            wvalid = 1'b1; wmask = 3'b111; waddr = 2'(k);
            wbank = 1'b0; wdata = 6'(k * 21);
            step();
            wbank = 1'b1; wdata = 6'((3 - k) * 21);
            step();
        end
        wvalid = 1'b0;
        raddr = 4'b0101;
        #1 chk("indep_read_1_1", 64'(a_rdata), 64'hA95);
        for (int r1 = 0; r1 < 4; r1++) begin
            for (int r0 = 0; r0 < 4; r0++) begin
                step();
                raddr = 4'(r1 * 4 + r0);
                #1 chk("indep_sweep", 64'(a_rdata), 64'({6'((3 - r1) * 21), 6'(r0 * 21)}));
            end
        end

        // Registered read returns the pre-write value, then the new one
        step();
        wvalid = 1'b1; wbank = 1'b0; waddr = 2'd0; wdata = 6'h15; wmask = 3'b111;
        step();
        wdata = 6'h3F; raddr = 4'b0000;
        step();
        wvalid = 1'b0;
        chk("rl1_old", 64'(b_rdata), 64'hFD5);
        step();
        chk("rl1_new", 64'(b_rdata), 64'hFFF);

        // Clear with a same-cycle write; second clear_req during the sweep is ignored
        wvalid = 1'b1; wbank = 1'b0; waddr = 2'd3; wdata = 6'h2A; wmask = 3'b111; clear_req = 1'b1;
        step();
        wvalid = 1'b0;
        chk("clr_busy_0", 64'(a_busy), 64'h1);
        chk("clr_wready_0", 64'(a_wready), 64'h0);
        step();
        clear_req = 1'b0;
        chk("clr_busy_1", 64'(a_busy), 64'h1);
        step();
        chk("clr_busy_2", 64'(a_busy), 64'h1);
        raddr = 4'b1000;
        #1 chk("clr_mid_a", 64'(a_rdata), 64'h540);
        raddr = 4'b0111;
        #1 chk("clr_mid_b", 64'(a_rdata), 64'h02A);
        step();
        chk("clr_busy_3", 64'(a_busy), 64'h1);
        step();
        chk("clr_done_busy", 64'(a_busy), 64'h0);
        chk("clr_done_wready", 64'(a_wready), 64'h1);
        for (int r = 0; r < 16; r++) begin
            raddr = 4'(r);
            #1 chk("clr_all_zero", 64'(a_rdata), 64'h0);
            step();
        end

        // Reset during the second cycle of CLEAR
        wvalid = 1'b1; wbank = 1'b1; waddr = 2'd3; wdata = 6'h3F; wmask = 3'b111; raddr = 4'b1100;
        step();
        wvalid = 1'b0; clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        step();
        #2 ASYNCRESET = 1'b1;
        #1;
        chk("rstclr_busy", 64'(a_busy), 64'h0);
        chk("rstclr_rdata", 64'(a_rdata), 64'h0);
        chk("rstclr_rl1", 64'(b_rdata), 64'h0);
        step();
        ASYNCRESET = 1'b0;
        #1 chk("rstclr_wready", 64'(a_wready), 64'h1);
        wvalid = 1'b1; wbank = 1'b1; waddr = 2'd3; wdata = 6'h2D; wmask = 3'b111;
        step();
        wvalid = 1'b0;
        chk("rstclr_write", 64'(a_rdata), 64'hB40);

        // Out-of-range writes and reads on the 3x3 instance
        c_wvalid = 1'b1; c_wbank = 2'd0; c_waddr = 2'd3; c_wdata = 6'h3F; c_wmask = 3'b111;
        chk("oor_wready_addr", 64'(c_wready), 64'h1);
        step();
        c_wbank = 2'd3; c_waddr = 2'd0;
        chk("oor_wready_bank", 64'(c_wready), 64'h1);
        step();
        c_wvalid = 1'b0;
        c_raddr = 6'b111111;
        #1 chk("oor_read", 64'(c_rdata), 64'h0);
        c_raddr = 6'b000000;
        #1 chk("oor_no_change", 64'(c_rdata), 64'h0);
        step();
        c_wvalid = 1'b1; c_wbank = 2'd2; c_waddr = 2'd2; c_wdata = 6'h1B; c_wmask = 3'b111;
        c_raddr = 6'b100000;
        step();
        c_wvalid = 1'b0;
        chk("c_bank2_write", 64'(c_rdata), 64'h1B000);

        // Randomised traffic; a stalled request holds its payload until accepted
        for (int n = 0; n < 400; n++) begin
            if (!(mbusy[0] && wvalid)) begin
                wvalid = 1'($urandom_range(0, 1)); wbank = 1'($urandom); waddr = 2'($urandom);
                wdata = 6'($urandom); wmask = 3'($urandom);
            end
            if (!(mbusy[1] && c_wvalid)) begin
                c_wvalid = 1'($urandom_range(0, 1)); c_wbank = 2'($urandom); c_waddr = 2'($urandom);
                c_wdata = 6'($urandom); c_wmask = 3'($urandom);
            end
            raddr     = 4'($urandom);
            c_raddr   = 6'($urandom);
            clear_req = ($urandom_range(0, 15) == 0);
            c_clear   = ($urandom_range(0, 15) == 0);
            step();
        end
        wvalid = 1'b0; c_wvalid = 1'b0; clear_req = 1'b0; c_clear = 1'b0;
        repeat (6) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/banked_array_regfile.md
Name: banked_array_regfile

Overview:
- Parameterised banked register file holding NBANKS x DEPTH entries; each entry is ELEMS elements of EWIDTH bits.
- Provides one dynamically indexed read port per bank, with read port b reading bank b only.
- Adds a handshaked masked write port and a bulk-clear sequencer.
- Used as generic table storage behind dynamic-index array reads in generated designs.

Parameters:
- NBANKS, 2, number of banks, which is also the number of read ports (>=1).
- DEPTH, 4, entries per bank (>=2, need not be a power of two).
- ELEMS, 3, elements per entry (>=1).
- EWIDTH, 2, bits per element (>=1).
- READ_LATENCY, 0, 0 = combinational read, 1 = registered read.
- AW (derived), max(1, clog2(DEPTH)), address width.
- BW (derived), max(1, clog2(NBANKS)), bank select width.

Ports:
- CLK  in  1  clock, rising edge.
- ASYNCRESET  in  1  asynchronous active-high reset.
- wvalid  in  1  write request.
- wready  out  1  write accepted when wvalid && wready.
- wbank  in  BW  target bank.
- waddr  in  AW  target entry.
- wdata  in  ELEMS*EWIDTH  element e at bits [e*EWIDTH +: EWIDTH].
- wmask  in  ELEMS  per-element write enable.
- raddr  in  NBANKS*AW  read address for bank b at bits [b*AW +: AW].
- rdata  out  NBANKS*ELEMS*EWIDTH  bank b entry at bits [b*ELEMS*EWIDTH +: ELEMS*EWIDTH], element order as wdata.
- clear_req  in  1  pulse to zero all entries.
- busy  out  1  clear sequence in progress.

Behaviour:
- Reset (asynchronous, active-high): all storage and any read register are 0, state is IDLE, clear counter is 0, busy=0, wready=1 once ASYNCRESET deasserts, rdata=0.
- Write:
  - A write is accepted on a rising edge with wvalid && wready.
  - Only elements with wmask[e]=1 are updated; other elements keep their value.
  - New data is visible on a READ_LATENCY=0 read in the cycle after acceptance.
  - wmask=0 is accepted with no storage change.
  - wbank>=NBANKS or waddr>=DEPTH is accepted and ignored; no storage changes.
- Read, READ_LATENCY=0:
  - rdata[b] combinationally equals storage[b][raddr[b]].
  - An out-of-range raddr returns 0.
- Read, READ_LATENCY=1:
  - rdata[b] is registered at the edge from storage[b][raddr[b]] as it is before that edge's write (read-before-write, no bypass).
  - The read register updates every cycle, including during CLEAR.
- Independence: read ports are independent; any number of ports may use the same address.
- State machine IDLE:
  - wready=1, busy=0.
  - clear_req=1 moves to CLEAR and sets counter=0.
  - A write accepted in the same cycle as clear_req still commits, and is then erased by the sweep.
- State machine CLEAR:
  - wready=0, busy=1.
  - Each cycle zeroes entry [counter] in all banks, then increments counter.
  - When counter==DEPTH-1, that entry is zeroed and the state returns to IDLE.
  - The sweep takes exactly DEPTH cycles; busy is high for DEPTH cycles.
  - clear_req in CLEAR is ignored; no restart, no queueing.
  - wvalid is held off by wready=0; the requester must keep wvalid asserted and its payload stable until accepted.
  - Reads during CLEAR return current storage: swept entries read 0, unswept entries read old data.
- Reset mid-CLEAR: aborts immediately to IDLE with all storage 0.
- Width rules:
  - No arithmetic on data.
  - The counter is AW bits.
  - Address comparisons against DEPTH and NBANKS are done at full width before truncation.

Test Plan:
- Reset and mask, defaults: assert ASYNCRESET mid-cycle; all rdata=0 immediately, wready=1 after release. Then write bank1 addr2, wdata={e2=3,e1=1,e0=2}, wmask=3'b101; set raddr1=2; next cycle rdata bank1 = {e2=3,e1=0,e0=2}, bank0 remains 0.
- Independent reads: fill bank0 addr k with all elements = k (k=0..3) and bank1 addr k with 3-k. Set raddr0=1, raddr1=1 -> bank0 {1,1,1}, bank1 {2,2,2}. Sweep all 16 raddr combinations; every combination matches.
- READ_LATENCY=1 read-before-write: in the same cycle, write bank0 addr0 = all 3 and set raddr0=0 (old value all 1). Next cycle rdata = all 1; the cycle after = all 3.
- Clear, DEPTH=4: with storage filled, pulse clear_req together with a write to bank0 addr3. busy=1 and wready=0 for exactly 4 cycles; after cycle 2, addr0-1 read 0 and addr2-3 read old values. At the end everything reads 0, including addr3. A second clear_req during busy leaves busy length unchanged.
- Out-of-range, DEPTH=3, NBANKS=3: write waddr=3 and wbank=3 -> both accepted (wready=1), no storage changes. raddr=3 on each port -> rdata=0.
- Reset mid-clear: assert ASYNCRESET during cycle 2 of CLEAR -> busy=0 and all rdata=0 at once. After release, wready=1 and normal writes work.
